bus_arbiter_rr: RTL and testbench
=================================

Name: bus_arbiter_rr

Overview:
- Round-robin arbiter and watchdog for the shared system bus used by the DMA-capable custom-instruction blocks.
- Collects `requestTransaction` lines from up to `nrOfMasters` bus masters and issues one registered, one-hot `transactionGranted`.
- Tracks each transaction from begin to end by monitoring the shared bus control lines.
- Recovers the bus when a granted master never starts its transaction, or when a transaction never ends.

Parameters:
- nrOfMasters, 4, number of requesters; legal range 2..16.
- grantTimeout, 16, cycles a grant may stay unused before it is revoked; legal range 2..255.
- busTimeout, 1024, maximum cycles from begin to end of a transaction; 0 disables the watchdog; maximum 65535.

Ports:
- clock, input, 1, system clock; all state changes on the rising edge.
- reset, input, 1, asynchronous active-low reset (0 = reset).
- requestTransaction, input, nrOfMasters, one request line per master; bit i belongs to master i.
- transactionGranted, output, nrOfMasters, registered one-hot grant.
- beginTransactionIn, input, 1, shared bus begin strobe.
- endTransactionIn, input, 1, shared bus end strobe.
- busErrorOut, output, 1, registered one-cycle bus error pulse on watchdog expiry.
- endTransactionOut, output, 1, registered one-cycle end strobe driven by the arbiter after a watchdog error.
- activeMaster, output, 4, index of the current or last granted master.
- busIdle, output, 1, high when state is IDLE.

Behaviour:
- Reset (asynchronous, reset=0), all outputs and state return to:
  - transactionGranted=0, busErrorOut=0, endTransactionOut=0, activeMaster=0, busIdle=1.
  - RR pointer=nrOfMasters-1, so master 0 has first priority.
  - Both counters=0, state IDLE.
  - Reset mid-transaction drops the grant immediately; no error or end strobe is issued.
- States: IDLE, GRANTED, ACTIVE, ERROR, END.
- IDLE:
  - If any request bit is 1 at a rising edge, select the first set bit searching (pointer+1) mod N upward, with wrap.
  - On that edge: set transactionGranted[sel]=1, activeMaster=sel, pointer=sel, grant counter=0, go to GRANTED.
  - Grant latency is 1 cycle from the request being sampled. No requests: stay in IDLE.
- GRANTED, evaluated in priority order:
  - (1) beginTransactionIn=1: go to ACTIVE, clear grant on this edge, watchdog counter=0.
  - (2) requestTransaction[activeMaster]=0: go to IDLE, clear grant.
  - (3) grant counter==grantTimeout-1: go to IDLE, clear grant. The pointer keeps the revoked master, so it gets lowest priority next round.
  - (4) Otherwise increment the grant counter.
- ACTIVE:
  - endTransactionIn=1: go to IDLE. This has priority over a watchdog expiry in the same cycle.
  - Otherwise, with busTimeout≠0 and counter==busTimeout-1: go to ERROR.
  - Otherwise increment the counter, saturating when busTimeout=0.
  - beginTransactionIn while ACTIVE is ignored.
- ERROR: busErrorOut=1 for exactly one cycle, then go to END.
- END:
  - endTransactionOut=1 for exactly one cycle, then go to IDLE.
  - An endTransactionIn arriving in ERROR or END is ignored; the sequence still completes.
- Back-to-back operation:
  - IDLE is always visited for at least one cycle between transactions, so the minimum gap from end to next grant is 1 cycle.
  - Re-arbitration happens in that IDLE cycle.
- Grant is never asserted outside GRANTED; at most one grant bit is ever set (one-hot).
- Request bits of non-granted masters may change at any time without effect on the current transaction.
- busIdle is combinational from the state register.

Test Plan:
- Reset, then raise requestTransaction=4'b0001 → transactionGranted=4'b0001 one cycle later. Then beginTransactionIn pulse → grant drops the same edge. Then endTransactionIn → busIdle=1.
- requestTransaction=4'b1111 held; complete 4 transactions → grants in order 0001, 0010, 0100, 1000, then 0001 again (wrap-around).
- Grant master 2, never begin → grant held exactly 16 cycles, then revoked. The next grant goes to master 3 when requestTransaction=4'b1100.
- Set busTimeout=8; begin with no end → busErrorOut pulses at cycle 8 after begin, endTransactionOut pulses on the following cycle, then IDLE.
- With busTimeout=8, endTransactionIn on exactly cycle 8 → no busErrorOut, direct return to IDLE. Also: master drops its request while GRANTED → grant clears on the next edge.
- Assert reset=0 asynchronously while ACTIVE (mid-cycle) → grant and state clear immediately without a clock edge. After release, master 0 wins a simultaneous request 4'b1001.

Source files
------------

// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter with grant-timeout and transaction watchdog.
// Tracks each granted transaction through the shared begin/end strobes and recovers a stuck bus.
module bus_arbiter_rr #(
    parameter int nrOfMasters  = 4,
    parameter int grantTimeout = 16,
    parameter int busTimeout   = 1024
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [nrOfMasters-1:0] requestTransaction,
    output logic [nrOfMasters-1:0] transactionGranted,
    input  logic                   beginTransactionIn,
    input  logic                   endTransactionIn,
    output logic                   busErrorOut,
    output logic                   endTransactionOut,
    output logic [3:0]             activeMaster,
    output logic                   busIdle
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GRANTED = 3'd1,
        ST_ACTIVE  = 3'd2,
        ST_ERROR   = 3'd3,
        ST_END     = 3'd4
    } state_e;

    localparam logic [7:0]  GRANT_LAST = 8'(grantTimeout - 1);
    localparam logic [15:0] BUS_LAST   = 16'(busTimeout - 1);
    localparam bit          WD_EN      = (busTimeout != 0);

    state_e                   state_q, state_d;
    logic [nrOfMasters-1:0]   grant_q, grant_d;
    logic [3:0]               ptr_q, ptr_d;
    logic [3:0]               act_q, act_d;
    logic [7:0]               gcnt_q, gcnt_d;
    logic [15:0]              wcnt_q, wcnt_d;
    logic                     err_q, err_d;
    logic                     endo_q, endo_d;

    logic [nrOfMasters-1:0]   rot_s;
    logic [4:0]               off_s;
    logic [4:0]               sum_s;
    logic                     found_s;
    logic [3:0]               sel_s;
    logic                     req_any_s;
    logic                     req_own_s;

    // Rotate requests so the master after the pointer sits at bit 0, then take the first set bit.
    always_comb begin
        rot_s   = nrOfMasters'({requestTransaction, requestTransaction} >> (ptr_q + 4'd1));
        found_s = 1'b0;
        off_s   = 5'd0;
        for (int i = 0; i < nrOfMasters; i++) begin
            if (!found_s && rot_s[i]) begin
                found_s = 1'b1;
                off_s   = 5'(i);
            end else begin
                found_s = found_s;
            end
        end
        sum_s = 5'(ptr_q) + 5'd1 + off_s;
        if (sum_s >= 5'(nrOfMasters)) begin
            sel_s = 4'(sum_s - 5'(nrOfMasters));
        end else begin
            sel_s = 4'(sum_s);
        end
    end

    assign req_any_s = |requestTransaction;
    assign req_own_s = |(requestTransaction & grant_q);

    // State and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= 4'(nrOfMasters - 1);
            act_q   <= 4'd0;
            gcnt_q  <= 8'd0;
            wcnt_q  <= 16'd0;
            err_q   <= 1'b0;
            endo_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            act_q   <= act_d;
            gcnt_q  <= gcnt_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
            endo_q  <= endo_d;
        end
    end

    // Next-state decision; GRANTED conditions are ordered by priority.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_any_s) begin
                    state_d = ST_GRANTED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANTED: begin
                if (beginTransactionIn) begin
                    state_d = ST_ACTIVE;
                end else if (!req_own_s) begin
                    state_d = ST_IDLE;
                end else if (gcnt_q == GRANT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_GRANTED;
                end
            end
            ST_ACTIVE: begin
                if (endTransactionIn) begin
                    state_d = ST_IDLE;
                end else if (WD_EN && (wcnt_q == BUS_LAST)) begin
                    state_d = ST_ERROR;
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ERROR: state_d = ST_END;
            ST_END:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Registered-output and counter updates derived from the transition being taken.
    always_comb begin
        ptr_d  = ptr_q;
        act_d  = act_q;
        err_d  = (state_d == ST_ERROR);
        endo_d = (state_d == ST_END);
        if ((state_q == ST_IDLE) && (state_d == ST_GRANTED)) begin
            grant_d = {{(nrOfMasters-1){1'b0}}, 1'b1} << sel_s;
            ptr_d   = sel_s;
            act_d   = sel_s;
        end else if ((state_q == ST_GRANTED) && (state_d == ST_GRANTED)) begin
            grant_d = grant_q;
        end else begin
            grant_d = '0;
        end
        if ((state_q == ST_GRANTED) && (state_d == ST_GRANTED)) begin
            gcnt_d = gcnt_q + 8'd1;
        end else begin
            gcnt_d = 8'd0;
        end
        // With the watchdog disabled the counter simply parks at its maximum.
        if ((state_q == ST_ACTIVE) && (state_d == ST_ACTIVE)) begin
            if (wcnt_q == 16'hFFFF) begin
                wcnt_d = wcnt_q;
            end else begin
                wcnt_d = wcnt_q + 16'd1;
            end
        end else begin
            wcnt_d = 16'd0;
        end
    end

    assign transactionGranted = grant_q;
    assign busErrorOut        = err_q;
    assign endTransactionOut  = endo_q;
    assign activeMaster       = act_q;
    assign busIdle            = (state_q == ST_IDLE);

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the arbitration rules.
module tb_bus_arbiter_rr;
    localparam int N  = 4;
    localparam int GT = 16;
    localparam int BT = 8;

    localparam int S_IDLE = 0, S_GRANTED = 1, S_ACTIVE = 2, S_ERROR = 3, S_END = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic [N-1:0] req;
    logic [N-1:0] grant;
    logic         beg, endi, err, endo, idle;
    logic [3:0]   act;

    int checks = 0;
    int errors = 0;

    int   m_st, m_ptr, m_act, m_gc, m_wc;
    logic m_err, m_endo;

    always #5 clock = ~clock;

    bus_arbiter_rr #(.nrOfMasters(N), .grantTimeout(GT), .busTimeout(BT)) dut (
        .clock(clock),
        .reset(reset),
        .requestTransaction(req),
        .transactionGranted(grant),
        .beginTransactionIn(beg),
        .endTransactionIn(endi),
        .busErrorOut(err),
        .endTransactionOut(endo),
        .activeMaster(act),
        .busIdle(idle)
    );

    function automatic int winner(logic [N-1:0] r, int p);
        for (int k = 1; k <= N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return p;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = S_IDLE; m_ptr = N - 1; m_act = 0; m_gc = 0; m_wc = 0;
        m_err = 1'b0; m_endo = 1'b0;
    endtask

    task automatic model_step();
        m_err  = 1'b0;
        m_endo = 1'b0;
        case (m_st)
            S_IDLE: if (req != '0) begin
                m_ptr = winner(req, m_ptr);
                m_act = m_ptr;
                m_gc  = 0;
                m_st  = S_GRANTED;
            end
            S_GRANTED: begin
                if (beg) begin m_st = S_ACTIVE; m_wc = 0; end
                else if (!req[m_act]) m_st = S_IDLE;
                else if (m_gc == GT - 1) m_st = S_IDLE;
                else m_gc++;
            end
            S_ACTIVE: begin
                if (endi) m_st = S_IDLE;
                else if (BT != 0 && m_wc == BT - 1) begin m_st = S_ERROR; m_err = 1'b1; end
                else if (m_wc < 65535) m_wc++;
            end
            S_ERROR: begin m_st = S_END; m_endo = 1'b1; end
            default: m_st = S_IDLE;
        endcase
    endtask

    task automatic check_all(string tag);
        logic [N-1:0] eg;
        eg = '0;
        if (m_st == S_GRANTED) eg[m_act] = 1'b1;
        chk({tag, "_grant"}, 32'(grant), 32'(eg));
        chk({tag, "_err"},   32'(err),   32'(m_err));
        chk({tag, "_endo"},  32'(endo),  32'(m_endo));
        chk({tag, "_act"},   32'(act),   32'(m_act));
        chk({tag, "_idle"},  32'(idle),  32'(m_st == S_IDLE));
    endtask

    task automatic cyc(string tag);
        @(posedge clock);
        #1;
        model_step();
        check_all(tag);
    endtask

    task automatic reset_dut();
        @(negedge clock);
        reset = 1'b0; req = '0; beg = 1'b0; endi = 1'b0;
        #1;
        model_reset();
        check_all("rst");
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic wait_grant(string tag);
        int n;
        n = 0;
        while (grant == '0 && n < 8) begin
            cyc(tag);
            n++;
        end
        chk({tag, "_granted"}, 32'(grant != '0), 32'd1);
    endtask

    initial begin
        int n, k;
        logic [N-1:0] eo;
        reset = 1'b0; req = '0; beg = 1'b0; endi = 1'b0;
        model_reset();
        @(negedge clock);
        check_all("por");
        reset = 1'b1;

        // Basic single transaction
        req = 4'b0001;
        cyc("t1_req");
        chk("t1_grant0", 32'(grant), 32'(4'b0001));
        beg = 1'b1;
        cyc("t1_beg");
        chk("t1_grant_drop", 32'(grant), 32'd0);
        beg = 1'b0;
        cyc("t1_act");
        endi = 1'b1; req = '0;
        cyc("t1_end");
        chk("t1_idle", 32'(idle), 32'd1);
        endi = 1'b0;

        // Round-robin order with wrap-around
        reset_dut();
        req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            wait_grant("t2_wait");
            eo = 4'b0001 << (t % 4);
            chk("t2_order", 32'(grant), 32'(eo));
            beg = 1'b1;
            cyc("t2_beg");
            beg = 1'b0;
            endi = 1'b1;
            cyc("t2_end");
            endi = 1'b0;
        end
        req = '0;

        // Grant timeout and demoted priority of the revoked master
        reset_dut();
        req = 4'b0100;
        cyc("t3_req");
        chk("t3_g2", 32'(grant), 32'(4'b0100));
        req = 4'b1100;
        n = 1;
        while (grant == 4'b0100 && n < 40) begin
            cyc("t3_hold");
            if (grant == 4'b0100) n++;
        end
        chk("t3_hold_cycles", 32'(n), 32'd16);
        cyc("t3_next");
        chk("t3_next_grant", 32'(grant), 32'(4'b1000));

        // Watchdog expiry, ERROR then END; an end strobe during ERROR is ignored
        beg = 1'b1;
        cyc("t4_beg");
        beg = 1'b0;
        k = 0;
        while (!err && k < 20) begin
            cyc("t4_run");
            k++;
        end
        chk("t4_err_cycle", 32'(k), 32'd8);
        req = '0; endi = 1'b1;
        cyc("t4_end");
        chk("t4_endo", 32'(endo), 32'd1);
        chk("t4_err_clear", 32'(err), 32'd0);
        endi = 1'b0;
        cyc("t4_back");
        chk("t4_idle", 32'(idle), 32'd1);

        // End on the last watchdog cycle wins over expiry
        req = 4'b0001;
        wait_grant("t5_wait");
        beg = 1'b1;
        cyc("t5_beg");
        beg = 1'b0;
        repeat (7) cyc("t5_run");
        endi = 1'b1; req = '0;
        cyc("t5_end");
        chk("t5_no_err", 32'(err), 32'd0);
        chk("t5_idle", 32'(idle), 32'd1);
        endi = 1'b0;
        cyc("t5_after");
        chk("t5_no_err2", 32'(err), 32'd0);

        // Request dropped while GRANTED
        req = 4'b0010;
        wait_grant("t5b_wait");
        chk("t5b_grant", 32'(grant), 32'(4'b0010));
        req = '0;
        cyc("t5b_drop");
        chk("t5b_cleared", 32'(grant), 32'd0);

        // Asynchronous reset in ACTIVE, then master 0 wins 1001
        req = 4'b0001;
        wait_grant("t6_wait");
        beg = 1'b1;
        cyc("t6_beg");
        beg = 1'b0;
        chk("t6_active", 32'(idle), 32'd0);
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        check_all("t6_async");
        chk("t6_idle_now", 32'(idle), 32'd1);
        #3;
        reset = 1'b1;
        req = 4'b1001;
        cyc("t6_rearb");
        chk("t6_m0_wins", 32'(grant), 32'(4'b0001));

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) req = 4'($urandom_range(0, 15));
            beg  = ($urandom_range(0, 3) == 0);
            endi = ($urandom_range(0, 5) == 0);
            cyc("rnd");
        end
        req = '0; beg = 1'b0; endi = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
